prbs_check_sequencer: RTL and testbench

Run controller for one PRBS check. It latches a test configuration, resets the downstream pattern detector, enables the PRBS-15 source and watches for the detector's flag. It ends each run with pass, fail or error and reports how many cycles the run took. It sits between the host/register interface and the PRBS generator plus pattern detector pair.

---
 rtl/prbs_check_sequencer.sv | 146 ++++++++++++++
 tb/tb_prbs_check_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/prbs_check_sequencer.sv
// Run controller for one PRBS-15 check: latch config, reset detector, run, report result.
// Latency: start accepted at t -> prbs_en high at t+1+RST_CYCLES; done one cycle after run exit.
// Backpressure: none; start is sampled only in IDLE, abort only acts in RUN.
module prbs_check_sequencer #(
  parameter int RST_CYCLES = 2,
  parameter int TO_W       = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            abort,
  input  logic [31:0]     cfg_pattern,
  input  logic [3:0]      cfg_n,
  input  logic [TO_W-1:0] cfg_timeout,
  input  logic            pattern_detected,
  output logic            det_rst,
  output logic            prbs_en,
  output logic [31:0]     pattern,
  output logic [3:0]      n,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            fail,
  output logic            err,
  output logic [TO_W-1:0] elapsed
);

  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_ld_cnt;
  logic [TO_W-1:0] r_limit;
  logic            r_det_rst;
  logic            r_prbs_en;
  logic [31:0]     r_pattern;
  logic [3:0]      r_n;
  logic            r_busy;
  logic            r_done;
  logic            r_pass;
  logic            r_fail;
  logic            r_err;
  logic [TO_W-1:0] r_elapsed;

  // One extra bit so the timeout compare never sees a wrapped count.
  logic [TO_W:0]   w_elapsed_inc;
  logic [TO_W-1:0] w_elapsed_sat;
  logic            w_timeout;

  assign w_elapsed_inc = {1'b0, r_elapsed} + {{TO_W{1'b0}}, 1'b1};
  assign w_elapsed_sat = (&r_elapsed) ? r_elapsed : w_elapsed_inc[TO_W-1:0];
  assign w_timeout     = (r_limit != '0) && (w_elapsed_inc == {1'b0, r_limit});

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ld_cnt  <= '0;
      r_limit   <= '0;
      r_det_rst <= 1'b1;
      r_prbs_en <= 1'b0;
      r_pattern <= '0;
      r_n       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_err     <= 1'b0;
      r_elapsed <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_det_rst <= 1'b1;
          r_prbs_en <= 1'b0;
          if (start) begin
            if (cfg_n != 4'd0) begin
              r_pattern <= cfg_pattern;
              r_n       <= cfg_n;
              r_limit   <= cfg_timeout;
              r_pass    <= 1'b0;
              r_fail    <= 1'b0;
              r_err     <= 1'b0;
              r_elapsed <= '0;
              r_ld_cnt  <= '0;
              r_busy    <= 1'b1;
              r_state   <= S_LOAD;
            end else begin
              // A zero match count can never be reached by the detector.
              r_pass    <= 1'b0;
              r_fail    <= 1'b0;
              r_err     <= 1'b1;
              r_elapsed <= '0;
              r_done    <= 1'b1;
              r_state   <= S_DONE;
            end
          end
        end
        S_LOAD: begin
          if (r_ld_cnt == CW'(RST_CYCLES - 1)) begin
            r_det_rst <= 1'b0;
            r_prbs_en <= 1'b1;
            r_state   <= S_RUN;
          end else begin
            r_ld_cnt <= r_ld_cnt + 1'b1;
          end
        end
        S_RUN: begin
          r_elapsed <= w_elapsed_sat;
          // Priority: abort, then detection, then timeout.
          if (abort || pattern_detected || w_timeout) begin
            r_pass    <= !abort && pattern_detected;
            r_fail    <= abort || !pattern_detected;
            r_det_rst <= 1'b1;
            r_prbs_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign det_rst = r_det_rst;
  assign prbs_en = r_prbs_en;
  assign pattern = r_pattern;
  assign n       = r_n;
  assign busy    = r_busy;
  assign done    = r_done;
  assign pass    = r_pass;
  assign fail    = r_fail;
  assign err     = r_err;
  assign elapsed = r_elapsed;

endmodule

// File: tb/tb_prbs_check_sequencer.sv
// Scoreboard bench for prbs_check_sequencer: stimulus pushes expected results,
// a monitor pops and compares on every done pulse.
module tb_prbs_check_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_pattern = '0;
  logic [3:0]  cfg_n = '0;
  logic [15:0] cfg_timeout = '0;
  logic        pattern_detected = 1'b0;
  logic        det_rst, prbs_en, busy, done, pass, fail, err;
  logic [31:0] pattern;
  logic [3:0]  n;
  logic [15:0] elapsed;

  typedef struct packed {
    logic        pass;
    logic        fail;
    logic        err;
    logic [15:0] elapsed;
    logic [31:0] pattern;
    logic [3:0]  n;
  } exp_t;

  exp_t q[$];
  int   cmp_cnt = 0;
  int   err_cnt = 0;
  logic prev_done = 1'b0;

  prbs_check_sequencer #(.RST_CYCLES(2), .TO_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_pattern(cfg_pattern), .cfg_n(cfg_n), .cfg_timeout(cfg_timeout),
    .pattern_detected(pattern_detected),
    .det_rst(det_rst), .prbs_en(prbs_en), .pattern(pattern), .n(n),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .err(err),
    .elapsed(elapsed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic p, input logic f, input logic e,
                              input logic [15:0] el, input logic [31:0] pat,
                              input logic [3:0] nn);
    exp_t x;
    x.pass = p; x.fail = f; x.err = e; x.elapsed = el; x.pattern = pat; x.n = nn;
    return x;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      check("done_single_cycle", 64'(prev_done), 64'(0));
      check("done_busy_low", 64'(busy), 64'(0));
      check("done_prbs_en_low", 64'(prbs_en), 64'(0));
      check("done_det_rst_high", 64'(det_rst), 64'(1));
      if (q.size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL unexpected_done: got done=1, want no done");
      end else begin
        e = q.pop_front();
        check("res_pass", 64'(pass), 64'(e.pass));
        check("res_fail", 64'(fail), 64'(e.fail));
        check("res_err", 64'(err), 64'(e.err));
        check("res_elapsed", 64'(elapsed), 64'(e.elapsed));
        check("res_pattern", 64'(pattern), 64'(e.pattern));
        check("res_n", 64'(n), 64'(e.n));
      end
    end
    prev_done <= rst ? 1'b0 : done;
  end

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Start a valid run; returns positioned in the first RUN cycle.
  task automatic launch(input logic [31:0] pat, input logic [3:0] nn, input logic [15:0] to);
    cfg_pattern = pat; cfg_n = nn; cfg_timeout = to;
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("load_busy", 64'(busy), 64'(1));
    check("load_prbs_en_c1", 64'(prbs_en), 64'(0));
    check("load_det_rst", 64'(det_rst), 64'(1));
    step(1);
    check("load_prbs_en_c2", 64'(prbs_en), 64'(0));
    step(1);
    check("run_prbs_en", 64'(prbs_en), 64'(1));
    check("run_det_rst", 64'(det_rst), 64'(0));
    check("run_pattern", 64'(pattern), 64'(pat));
    check("run_n", 64'(n), 64'(nn));
  endtask

  // Bounded wait for the monitor to consume all expectations, then return to IDLE.
  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) step(1);
    check("drain_queue_empty", 64'(q.size()), 64'(0));
    pattern_detected = 1'b0;
    abort = 1'b0;
    step(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    // Reset state
    step(3);
    check("rst_det_rst", 64'(det_rst), 64'(1));
    check("rst_prbs_en", 64'(prbs_en), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_flags", 64'({done, pass, fail, err}), 64'(0));
    check("rst_pattern", 64'(pattern), 64'(0));
    check("rst_elapsed", 64'(elapsed), 64'(0));
    rst = 1'b0;
    step(2);

    // Basic pass: detection on 40th RUN cycle
    q.push_back(mk(1'b1, 1'b0, 1'b0, 16'd40, 32'hDEADBEEF, 4'd3));
    launch(32'hDEADBEEF, 4'd3, 16'd100);
    step(39);
    pattern_detected = 1'b1;
    step(1);
    pattern_detected = 1'b0;
    drain();
    check("hold_pass_idle", 64'({pass, fail, err}), 64'(3'b100));

    // Timeout after exactly 10 RUN cycles
    q.push_back(mk(1'b0, 1'b1, 1'b0, 16'd10, 32'hA5A50F0F, 4'd2));
    launch(32'hA5A50F0F, 4'd2, 16'd10);
    cnt = 1;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (prbs_en) cnt++;
      else break;
    end
    check("timeout_prbs_cycles", 64'(cnt), 64'(10));
    drain();

    // Detection coincident with timeout: pass wins
    q.push_back(mk(1'b1, 1'b0, 1'b0, 16'd10, 32'h0BADF00D, 4'd4));
    launch(32'h0BADF00D, 4'd4, 16'd10);
    step(9);
    pattern_detected = 1'b1;
    step(1);
    pattern_detected = 1'b0;
    drain();

    // Abort coincident with detection: fail wins
    q.push_back(mk(1'b0, 1'b1, 1'b0, 16'd5, 32'h13572468, 4'd5));
    launch(32'h13572468, 4'd5, 16'd100);
    step(4);
    abort = 1'b1;
    pattern_detected = 1'b1;
    step(1);
    abort = 1'b0;
    pattern_detected = 1'b0;
    drain();

    // Bad config: cfg_n == 0, pattern/n keep previous latched values
    q.push_back(mk(1'b0, 1'b0, 1'b1, 16'd0, 32'h13572468, 4'd5));
    cfg_pattern = 32'hFFFF0000; cfg_n = 4'd0; cfg_timeout = 16'd7;
    start = 1'b1;
    step(1);
    start = 1'b0;
    check("badcfg_done", 64'(done), 64'(1));
    check("badcfg_busy", 64'(busy), 64'(0));
    check("badcfg_prbs_en", 64'(prbs_en), 64'(0));
    drain();

    // Reset on 5th RUN cycle: immediate reset values, no done pulse
    launch(32'h11112222, 4'd6, 16'd100);
    step(4);
    rst = 1'b1;
    #1;
    check("midrst_det_rst", 64'(det_rst), 64'(1));
    check("midrst_prbs_en", 64'(prbs_en), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_flags", 64'({done, pass, fail, err}), 64'(0));
    check("midrst_pattern", 64'(pattern), 64'(0));
    check("midrst_n", 64'(n), 64'(0));
    check("midrst_elapsed", 64'(elapsed), 64'(0));
    step(2);
    rst = 1'b0;
    step(3);
    // Normal run afterwards
    q.push_back(mk(1'b1, 1'b0, 1'b0, 16'd3, 32'hCAFEF00D, 4'd7));
    launch(32'hCAFEF00D, 4'd7, 16'd50);
    step(2);
    pattern_detected = 1'b1;
    step(1);
    pattern_detected = 1'b0;
    drain();

    // No limit, config changes ignored, elapsed saturates, abort ends run
    q.push_back(mk(1'b0, 1'b1, 1'b0, 16'hFFFF, 32'h12345678, 4'd9));
    launch(32'h12345678, 4'd9, 16'd0);
    cfg_pattern = 32'hFFFFFFFF; cfg_n = 4'd1; cfg_timeout = 16'd5;
    step(10);
    check("iso_pattern", 64'(pattern), 64'(32'h12345678));
    check("iso_n", 64'(n), 64'(9));
    check("iso_still_running", 64'(prbs_en), 64'(1));
    step(70000);
    check("sat_elapsed", 64'(elapsed), 64'(16'hFFFF));
    check("sat_busy", 64'(busy), 64'(1));
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
